debounce_bank: RTL
==================

# debounce_bank

Multi-channel switch/button debouncer for board-level inputs feeding the user logic. Each channel synchronises its raw input and accepts a new level only after it has been stable for a programmable number of slow ticks. It also reports the accepted transitions as single-cycle rise and fall pulses. One shared tick generator divides the system clock for all channels.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent inputs (1–32).
- `CLK_DIV`, 25000: system cycles per slow tick (≥1). 25000 @ 100 kHz gives 4 Hz.
- `STABLE_TICKS`, 3: consecutive ticks a new level must persist before it is accepted (≥1).
- `RESET_LEVEL`, 0: value of every `signal_out` bit in reset.

Ports:
- `clk` in 1: system clock. There is one clock; everything is in this domain.
- `rst_n` in 1: reset, asynchronous and active-low. Assertion is asynchronous; deassertion is synchronous to `clk` at board level.
- `signal_in` in CHANNELS: raw, asynchronous, bouncy inputs.
- `signal_out` out CHANNELS: debounced levels.
- `rise` out CHANNELS: 1-cycle pulse when `signal_out[i]` goes 0→1.
- `fall` out CHANNELS: 1-cycle pulse when `signal_out[i]` goes 1→0.
- `tick` out 1: slow-tick strobe, exported for reuse (LED blink, scan).

## Operation
- **Synchroniser.** 2-flop synchroniser per channel, `sync[i]`. Both flops reset to `RESET_LEVEL`.
- **Tick generator.**
  - Counter `div` runs 0..CLK_DIV-1 and wraps to 0.
  - `tick` = (`div` == CLK_DIV-1), combinational from the register.
  - When CLK_DIV = 1, `tick` is constantly 1 after reset.
- **Per-channel counter.** Channel i holds a stability counter `cnt[i]`, width clog2(STABLE_TICKS+1). Each cycle, in priority order:
  1. `sync[i]` == `signal_out[i]`: `cnt[i]` ← 0. Any bounce back to the old level restarts qualification.
  2. Else, if `tick` and `cnt[i]` == STABLE_TICKS-1: `signal_out[i]` ← `sync[i]`, `cnt[i]` ← 0, and pulse `rise[i]` or `fall[i]` in the next cycle.
  3. Else, if `tick`: `cnt[i]` ← `cnt[i]`+1.
  4. Else: hold.
- **Edge pulses.** `rise` and `fall` are registered. Each is high exactly in the first cycle in which the new `signal_out` value is visible. `rise[i]` and `fall[i]` are never high together.
- **Channel independence.** Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle.
- **Tick alignment.** The tick counter free-runs and is never re-aligned to input activity.

## Timing
- **Reset values.** While `rst_n`=0:
  - `signal_out` = {CHANNELS{RESET_LEVEL}}.
  - `rise` = `fall` = 0.
  - `tick` = 0 (CLK_DIV>1); `div` = 0; all `cnt` = 0.
- **Reset mid-qualification.** Partial counts are discarded, and no pulse is emitted on reset entry or exit.
- **Acceptance latency.** For a clean step on `signal_in[i]`:
  - `sync` follows after 2 clk edges.
  - Acceptance occurs on the STABLE_TICKS-th tick that sees the mismatch.
  - Latency is between 2+(STABLE_TICKS-1)·CLK_DIV+1 and 2+STABLE_TICKS·CLK_DIV cycles.
  - `rise`/`fall` follows `signal_out` with no extra latency (same edge).
- **Short pulses.** Inputs shorter than (STABLE_TICKS-1)·CLK_DIV+1 cycles are never accepted.
- **Wrap-around.** `div` wraps CLK_DIV-1→0 with `tick` high for exactly one cycle. `cnt` never exceeds STABLE_TICKS-1.
- **Simultaneous events.** If the input returns to the old level in the same cycle as the qualifying tick, rule 1 wins: no change, count cleared.

## Structure
- **Shared package `debounce_pkg`.**
  - `clog2` helper function.
  - Default constants DEB_CLK_DIV=25000, DEB_STABLE_TICKS=3.
  - These are shared with other board-input blocks.
- **Sub-module `tick_gen`** (params CLK_DIV; ports `clk`, `rst_n`, `tick`). It is instantiated once.
- **Per-channel logic** is written as a generate loop, not a separate module.

## Test plan
Bench config: CHANNELS=4, CLK_DIV=10, STABLE_TICKS=3, RESET_LEVEL=0.

- **Reset.** Hold `rst_n`=0 with `signal_in`=4'hF → `signal_out`=0, `rise`=`fall`=0, `tick`=0. After release, `tick` pulses every 10 cycles.
- **Clean press.** `signal_in[0]` 0→1 held → `signal_out[0]`=1 within 23–32 cycles, with one `rise[0]` pulse aligned to the change. No activity on other channels.
- **Bounce.** On ch1, toggle `signal_in[1]` every 7 cycles for 100 cycles, then hold 1 → no output change during bouncing, then exactly one `rise[1]` after the hold qualifies.
- **Release and glitch.** With ch0 at 1, drive a 1-cycle low glitch → no `fall`. Then hold low → one `fall[0]`, `signal_out[0]`=0.
- **Simultaneous channels.** Step all 4 inputs to 1 in the same cycle → `rise`=4'hF in a single cycle and `signal_out`=4'hF.
- **Reset mid-qualification.** Assert `rst_n` 15 cycles after a step → outputs return to 0 immediately. After release, qualification restarts from 0 with no spurious pulse.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for board-input conditioning blocks.
// Imported by the tick generator and the debouncer bank.
package debounce_pkg;

    localparam int unsigned DEB_CLK_DIV      = 25000;
    localparam int unsigned DEB_STABLE_TICKS = 3;

    // Ceiling log2, floored at 1 so the result can always size a vector.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        int unsigned v;
        w = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v != 0) begin
            w++;
            v = v >> 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running clock divider producing a one-cycle strobe every CLK_DIV cycles.
// With CLK_DIV = 1 the strobe is permanently high.
module tick_gen
    import debounce_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEB_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned    DivW   = clog2(CLK_DIV);
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (div_q == DivMax) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DivW'(1);
        end
    end

    assign tick = (div_q == DivMax);

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: per-channel 2-flop synchroniser plus a tick-based
// stability counter, all sharing one slow tick; emits registered rise/fall pulses.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned CLK_DIV      = DEB_CLK_DIV,
    parameter int unsigned STABLE_TICKS = DEB_STABLE_TICKS,
    parameter bit          RESET_LEVEL  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] signal_in,
    output logic [CHANNELS-1:0] signal_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int unsigned     CntW    = clog2(STABLE_TICKS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

    tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic            meta_q;
        logic            sync_q;
        logic            level_q;
        logic            rise_q;
        logic            fall_q;
        logic [CntW-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_q  <= RESET_LEVEL;
                sync_q  <= RESET_LEVEL;
                level_q <= RESET_LEVEL;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                meta_q <= signal_in[i];
                sync_q <= meta_q;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                // A return to the accepted level always wins, even on a qualifying tick.
                if (sync_q == level_q) begin
                    cnt_q <= '0;
                end else if (tick && cnt_q == CntLast) begin
                    level_q <= sync_q;
                    cnt_q   <= '0;
                    rise_q  <= sync_q;
                    fall_q  <= ~sync_q;
                end else if (tick) begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
        end

        assign signal_out[i] = level_q;
        assign rise[i]       = rise_q;
        assign fall[i]       = fall_q;
    end

endmodule
